// File: rtl/chacha_state_gen.sv
// ChaCha20 initial-state generator: latches key/nonce/counter once, then
// streams one 4x4 initial matrix per block, bumping the counter itself.
module chacha_state_gen #(
  parameter int CTR_WORDS = 1,
  parameter int KEY128_EN = 0,
  parameter int NBLK_W    = 16
) (
  input  logic                      clk,
  input  logic                      clrMatrix,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [0:7][31:0]          key,
  input  logic [2:0][31:0]          nonce,
  input  logic [32*CTR_WORDS-1:0]   ctr_init,
  input  logic [NBLK_W-1:0]         nblk,
  input  logic                      key_len,
  input  logic                      abort,
  output logic                      st_valid,
  input  logic                      st_ready,
  output logic [3:0][3:0][31:0]     st_matrix,
  output logic                      st_last,
  output logic                      done,
  output logic                      ctr_ovf
);

  localparam int CW = 32 * CTR_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0][3:0][31:0] matrix_q, matrix_d;
  logic [NBLK_W-1:0]     rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic                  mode128;
  logic [3:0][31:0]      row0_load, row1_load, row2_load, row3_load, row3_bump;
  logic [CW-1:0]         ctr_cur, ctr_inc;

  // The 128-bit key mode only exists when the build enables it.
  assign mode128 = (KEY128_EN != 0) && key_len;

  // Row 0: "expand 32-byte k" or "expand 16-byte k" as little-endian words.
  assign row0_load[0] = 32'h61707865;
  assign row0_load[1] = mode128 ? 32'h3120646e : 32'h3320646e;
  assign row0_load[2] = mode128 ? 32'h79622d36 : 32'h79622d32;
  assign row0_load[3] = 32'h6b206574;

  // Rows 1 and 2 carry the key; a 128-bit key is simply repeated.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key_rows
      assign row1_load[gi] = key[gi];
      assign row2_load[gi] = mode128 ? key[gi] : key[gi+4];
    end
  endgenerate

  // Row 3 layout depends on how many words the counter occupies. The live
  // counter is read back from row 3 itself so there is one copy of it.
  generate
    if (CTR_WORDS == 2) begin : g_ctr64
      logic unused_nonce2;
      assign unused_nonce2 = ^nonce[2];
      assign ctr_cur   = {matrix_q[3][1], matrix_q[3][0]};
      assign row3_load = {nonce[1], nonce[0], ctr_init[63:32], ctr_init[31:0]};
      assign row3_bump = {matrix_q[3][3], matrix_q[3][2], ctr_inc[63:32], ctr_inc[31:0]};
    end else begin : g_ctr32
      assign ctr_cur   = matrix_q[3][0];
      assign row3_load = {nonce[2], nonce[1], nonce[0], ctr_init};
      assign row3_bump = {matrix_q[3][3:1], ctr_inc};
    end
  endgenerate

  assign ctr_inc = ctr_cur + CW'(1);

  // Next-state logic: configuration, per-handshake counter advance, overflow trap.
  always_comb begin
    state_d  = state_q;
    matrix_d = matrix_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          ovf_d = 1'b0;
          if (nblk == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = EMIT;
            rem_d    = nblk;
            matrix_d = {row3_load, row2_load, row1_load, row0_load};
          end
        end
      end
      EMIT: begin
        if (abort) begin
          // Abort wins over a coincident handshake: no further state, no done.
          state_d = IDLE;
        end else if (st_ready) begin
          rem_d = rem_q - NBLK_W'(1);
          if (rem_q == NBLK_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (&ctr_cur) begin
            // Counter would wrap with blocks still owed: park in ERR.
            state_d = ERR;
            ovf_d   = 1'b1;
          end else begin
            matrix_d[3] = row3_bump;
          end
        end
      end
      ERR: begin
        if (abort) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; clrMatrix also wipes the matrix.
  always_ff @(posedge clk) begin
    if (clrMatrix) begin
      state_q  <= IDLE;
      matrix_q <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      matrix_q <= matrix_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign st_valid  = (state_q == EMIT);
  assign st_last   = (state_q == EMIT) && (rem_q == NBLK_W'(1));
  assign st_matrix = matrix_q;
  assign done      = done_q;
  assign ctr_ovf   = ovf_q;

endmodule

// File: tb/tb_chacha_state_gen.sv
// Scoreboard bench for chacha_state_gen: stimulus pushes expected matrices,
// a negedge monitor pops and compares on every st_valid&&st_ready.
module tb_chacha_state_gen;

  typedef logic [3:0][3:0][31:0] mat_t;
  typedef struct {
    mat_t m;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic              clrMatrix, cfg_valid, cfg_ready, key_len, abort;
  logic              st_valid, st_ready, st_last, done, ctr_ovf;
  logic [0:7][31:0]  key;
  logic [2:0][31:0]  nonce;
  logic [31:0]       ctr_init;
  logic [15:0]       nblk;
  mat_t              st_matrix;

  logic              cfg_valid2, cfg_ready2, st_valid2, st_last2, done2, ctr_ovf2;
  logic [63:0]       ctr_init2;
  mat_t              st_matrix2;

  chacha_state_gen #(.CTR_WORDS(1), .KEY128_EN(1), .NBLK_W(16)) dut (
    .clk(clk), .clrMatrix(clrMatrix), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .key(key), .nonce(nonce), .ctr_init(ctr_init), .nblk(nblk), .key_len(key_len),
    .abort(abort), .st_valid(st_valid), .st_ready(st_ready), .st_matrix(st_matrix),
    .st_last(st_last), .done(done), .ctr_ovf(ctr_ovf)
  );

  chacha_state_gen #(.CTR_WORDS(2), .KEY128_EN(0), .NBLK_W(16)) dut2 (
    .clk(clk), .clrMatrix(clrMatrix), .cfg_valid(cfg_valid2), .cfg_ready(cfg_ready2),
    .key(key), .nonce(nonce), .ctr_init(ctr_init2), .nblk(nblk), .key_len(key_len),
    .abort(abort), .st_valid(st_valid2), .st_ready(1'b1), .st_matrix(st_matrix2),
    .st_last(st_last2), .done(done2), .ctr_ovf(ctr_ovf2)
  );

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  int unsigned rdy_prob = 100;
  bit rdy_pat[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkm(input string name, input mat_t act, input mat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: ChaCha initial state built straight from the sigma/tau strings.
  function automatic mat_t model(input logic [0:7][31:0] k, input logic [2:0][31:0] n,
                                 input logic [63:0] ctr, input logic k128, input bit wide);
    mat_t m;
    string s;
    s = k128 ? "expand 16-byte k" : "expand 32-byte k";
    for (int c = 0; c < 4; c++) begin
      m[0][c] = {s[4*c+3], s[4*c+2], s[4*c+1], s[4*c]};
      m[1][c] = k[c];
      m[2][c] = k128 ? k[c] : k[c+4];
    end
    m[3][0] = ctr[31:0];
    if (wide) begin
      m[3][1] = ctr[63:32];
      m[3][2] = n[0];
      m[3][3] = n[1];
    end else begin
      m[3][1] = n[0];
      m[3][2] = n[1];
      m[3][3] = n[2];
    end
    return m;
  endfunction

  function automatic logic [0:7][31:0] rkey();
    logic [0:7][31:0] r;
    for (int i = 0; i < 8; i++) r[i] = $urandom();
    return r;
  endfunction

  function automatic logic [2:0][31:0] rnonce();
    logic [2:0][31:0] r;
    for (int i = 0; i < 3; i++) r[i] = $urandom();
    return r;
  endfunction

  // Consumer ready: scripted pattern while one is queued, otherwise random.
  initial begin
    st_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_pat.size() > 0) st_ready = st_valid ? rdy_pat.pop_front() : 1'b0;
      else st_ready = ($urandom_range(0, 99) < rdy_prob);
    end
  end

  // Monitor: handshakes against scoreboard, stall freezing, done timing.
  initial begin
    exp_t e;
    logic exp_done;
    logic pend_done;
    bit stalled;
    mat_t held;
    pend_done = 1'b0;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      exp_done = pend_done;
      pend_done = 1'b0;
      if (done === 1'b1 || exp_done) chk1("done_pulse", done, exp_done);
      if (st_valid === 1'b1 && stalled) chkm("stall_frozen", st_matrix, held);
      if (st_valid === 1'b1 && st_ready === 1'b1) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_state: got %0h expected none", st_matrix);
        end else begin
          e = sb.pop_front();
          chkm("state_matrix", st_matrix, e.m);
          chk1("state_last", st_last, e.last);
          if (e.last && !abort && !clrMatrix) pend_done = 1'b1;
        end
      end else if (st_valid === 1'b1) begin
        stalled = 1'b1;
        held = st_matrix;
      end else begin
        stalled = 1'b0;
      end
      if (cfg_valid && cfg_ready === 1'b1 && nblk == 16'd0 && !clrMatrix) pend_done = 1'b1;
    end
  end

  task automatic drive_cfg(input logic [0:7][31:0] k, input logic [2:0][31:0] n,
                           input logic [31:0] c, input int nb, input logic kl);
    @(posedge clk);
    #1;
    cfg_valid = 1'b1;
    key = k;
    nonce = n;
    ctr_init = c;
    nblk = 16'(nb);
    key_len = kl;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    key = rkey();
    nonce = rnonce();
    ctr_init = $urandom();
    key_len = ~kl;
    nblk = 16'($urandom());
  endtask

  task automatic run_job(input logic [0:7][31:0] k, input logic [2:0][31:0] n,
                         input logic [31:0] c, input int nb, input logic kl);
    logic [32:0] room;
    bit ovf;
    int nem;
    int t;
    exp_t e;
    room = 33'h1_0000_0000 - {1'b0, c};
    ovf = (33'(nb) > room);
    nem = ovf ? int'(room) : nb;
    for (int i = 0; i < nem; i++) begin
      e.m = model(k, n, {32'h0, c + 32'(i)}, kl, 1'b0);
      e.last = (!ovf && i == nb - 1);
      sb.push_back(e);
    end
    t = 0;
    while (cfg_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    drive_cfg(k, n, c, nb, kl);
    @(negedge clk);
    chk1("ovf_cleared_on_cfg", ctr_ovf, 1'b0);
    t = 0;
    while (t < 400 && !(sb.size() == 0 && st_valid === 1'b0 &&
                        (ovf ? cfg_ready === 1'b0 : cfg_ready === 1'b1))) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      failures++;
      $display("FAIL job_timeout: got %0d pending expected 0 (ctr %h nblk %0d)", sb.size(), c, nb);
      sb.delete();
    end
    if (ovf) begin
      chk1("err_ovf", ctr_ovf, 1'b1);
      chk1("err_no_valid", st_valid, 1'b0);
      chk1("err_no_cfg_ready", cfg_ready, 1'b0);
      repeat (2) @(negedge clk);
      chk1("err_holds", cfg_ready, 1'b0);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk1("abort_err_idle", cfg_ready, 1'b1);
      chk1("ovf_sticky", ctr_ovf, 1'b1);
    end else begin
      chk1("no_ovf", ctr_ovf, 1'b0);
    end
    repeat (2) @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:7][31:0] k;
    logic [2:0][31:0] n;
    logic [31:0] c;
    clrMatrix = 1'b1;
    cfg_valid = 1'b0;
    cfg_valid2 = 1'b0;
    abort = 1'b0;
    key = '0;
    nonce = '0;
    ctr_init = '0;
    ctr_init2 = '0;
    nblk = '0;
    key_len = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrMatrix = 1'b0;
    @(negedge clk);
    chkm("rst_matrix", st_matrix, '0);
    chk1("rst_valid", st_valid, 1'b0);
    chk1("rst_last", st_last, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ovf", ctr_ovf, 1'b0);
    chk1("rst_cfg_ready", cfg_ready, 1'b1);

    // RFC 8439 block-function example state.
    for (int i = 0; i < 8; i++) k[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    n = {32'h00000000, 32'h4a000000, 32'h09000000};
    run_job(k, n, 32'd1, 1, 1'b0);

    // Streaming with a scripted stall pattern.
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_job(rkey(), rnonce(), 32'd1, 4, 1'b0);
    rdy_pat.delete();

    // Counter overflow, then a clean job clears the flag.
    run_job(rkey(), rnonce(), 32'hFFFF_FFFE, 3, 1'b0);
    run_job(rkey(), rnonce(), 32'h0000_0010, 2, 1'b0);

    // 128-bit key mode and a zero-block job.
    run_job(rkey(), rnonce(), $urandom(), 2, 1'b1);
    run_job(rkey(), rnonce(), $urandom(), 0, 1'b1);

    // Abort while stalled in EMIT.
    rdy_prob = 0;
    k = rkey();
    n = rnonce();
    c = $urandom();
    drive_cfg(k, n, c, 4, 1'b0);
    repeat (2) @(negedge clk);
    chkm("abort_pre_matrix", st_matrix, model(k, n, {32'h0, c}, 1'b0, 1'b0));
    chk1("abort_pre_valid", st_valid, 1'b1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk1("abort_emit_valid", st_valid, 1'b0);
    chk1("abort_emit_cfg_ready", cfg_ready, 1'b1);
    repeat (2) @(negedge clk);
    rdy_prob = 100;

    // clrMatrix mid-stream at block 2 of 5.
    k = rkey();
    n = rnonce();
    c = $urandom_range(0, 1000);
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.m = model(k, n, {32'h0, c + 32'(i)}, 1'b0, 1'b0);
      e.last = (i == 4);
      sb.push_back(e);
    end
    drive_cfg(k, n, c, 5, 1'b0);
    @(posedge clk);
    #1 clrMatrix = 1'b1;
    @(posedge clk);
    #1 clrMatrix = 1'b0;
    @(negedge clk);
    chkm("clr_matrix", st_matrix, '0);
    chk1("clr_valid", st_valid, 1'b0);
    chk1("clr_cfg_ready", cfg_ready, 1'b1);
    sb.delete();
    repeat (2) @(negedge clk);

    // Randomized jobs with random consumer backpressure.
    rdy_prob = 70;
    for (int j = 0; j < 16; j++) begin
      if ($urandom_range(0, 3) == 0) c = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else c = $urandom();
      run_job(rkey(), rnonce(), c, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    rdy_prob = 100;

    // 64-bit counter instance: carry from word 0 into word 1.
    k = rkey();
    n = rnonce();
    @(posedge clk);
    #1;
    cfg_valid2 = 1'b1;
    key = k;
    nonce = n;
    ctr_init2 = 64'h0000_0000_FFFF_FFFF;
    nblk = 16'd2;
    @(posedge clk);
    #1 cfg_valid2 = 1'b0;
    @(negedge clk);
    chkm("wide_blk0", st_matrix2, model(k, n, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b1));
    chk1("wide_blk0_valid", st_valid2, 1'b1);
    chk1("wide_blk0_last", st_last2, 1'b0);
    @(negedge clk);
    chkm("wide_blk1", st_matrix2, model(k, n, 64'h0000_0001_0000_0000, 1'b0, 1'b1));
    chk1("wide_blk1_last", st_last2, 1'b1);
    @(negedge clk);
    chk1("wide_done", done2, 1'b1);
    chk1("wide_idle_valid", st_valid2, 1'b0);
    chk1("wide_cfg_ready", cfg_ready2, 1'b1);
    chk1("wide_no_ovf", ctr_ovf2, 1'b0);
    repeat (2) @(negedge clk);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expected: got %0d expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chacha_state_gen.md
# chacha_state_gen

Parametrised ChaCha20 initial-state generator: successor to `ChaChaState`. It accepts a key, nonce, starting block counter and block count in one configuration handshake. It then emits one fully formed 4x4 initial matrix per block over a valid/ready stream, incrementing the counter itself. Constants are generated internally from the key-length mode. It sits between the AEAD control FSM and the quarter-round core, replacing per-block host reloading of `Block`.

## Interface
- `CTR_WORDS`, 1: counter width in 32-bit words (1 = IETF 32-bit counter / 96-bit nonce; 2 = original 64-bit counter / 64-bit nonce).
- `KEY128_EN`, 0: 1 enables the 128-bit key mode input `key_len`; 0 forces 256-bit mode.
- `NBLK_W`, 16: width of the block-count field.
- `clk` in 1: single clock, all logic on rising edge.
- `clrMatrix` in 1: synchronous, active-high reset. Also clears the matrix.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: high only in IDLE.
- `key` in `word_t [0:7]`: key words. In 128-bit mode only `key[0:3]` are used.
- `nonce` in `word_t [2:0]`: nonce words. `nonce[2]` is ignored when `CTR_WORDS=2`.
- `ctr_init` in `32*CTR_WORDS`: starting block counter.
- `nblk` in `NBLK_W`: number of states to emit.
- `key_len` in 1: 0 = 256-bit key, 1 = 128-bit key. Ignored when `KEY128_EN=0`.
- `abort` in 1: abandon current job.
- `st_valid` out 1: `st_matrix` holds a valid state.
- `st_ready` in 1: consumer accepts the state.
- `st_matrix` out `word_t [3:0][3:0]`: registered ChaCha initial state.
- `st_last` out 1: qualifies the final state of the job.
- `done` out 1: one-cycle pulse on normal job completion.
- `ctr_ovf` out 1: sticky counter-overflow flag.

## Operation
- FSM states: IDLE, EMIT, ERR.
- IDLE: `cfg_ready=1`. On `cfg_valid` the block latches key, nonce, counter, `nblk` and mode, and clears `ctr_ovf`.
  - `nblk=0`: stay in IDLE; `done` pulses the next cycle.
  - `nblk≥1`: load the matrix and go to EMIT.
- Matrix layout:
  - Row 0: constants. 256-bit mode uses 61707865 3320646e 79622d32 6b206574. 128-bit mode uses 61707865 3120646e 79622d36 6b206574.
  - Row 1: `key[0..3]`.
  - Row 2: `key[4..7]` in 256-bit mode; `key[0..3]` in 128-bit mode.
  - Row 3, `CTR_WORDS=1`: ctr, `nonce[0]`, `nonce[1]`, `nonce[2]`.
  - Row 3, `CTR_WORDS=2`: ctr[31:0], ctr[63:32], `nonce[0]`, `nonce[1]`.
- EMIT: `st_valid=1`. The matrix is held stable until `st_valid&&st_ready`. On each handshake the remaining count decrements:
  - Remaining reaches 0: go to IDLE and pulse `done` in the same edge.
  - Counter is all-ones and blocks remain: go to ERR and set `ctr_ovf`. The counter never wraps.
  - Otherwise: counter increments by 1 (carry across words when `CTR_WORDS=2`). Only row 3 is rewritten.
- `st_last` = EMIT and remaining==1.
- ERR: `st_valid=0`, `cfg_ready=0`. Exits to IDLE only on `abort` or `clrMatrix`. `ctr_ovf` stays high until the next accepted configuration or `clrMatrix`.
- `abort` in EMIT or ERR: go to IDLE next edge, `st_valid` drops, no `done`. `abort` in IDLE has no effect. If `abort` and an `st_ready` handshake fall in the same cycle, `abort` wins: the handshake counts as a transfer but no further state is emitted.
- Inputs other than `cfg_*` are don't-care outside the accepting cycle. Changes during EMIT do not affect output.

## Timing
- Reset values (edge with `clrMatrix=1`): state IDLE, `st_matrix` all zero, `st_valid=0`, `st_last=0`, `done=0`, `ctr_ovf=0`. `cfg_ready` reads 1 from the cycle after reset.
- `clrMatrix` mid-job: immediate return to IDLE at that edge; the job is lost and no `done` is issued.
- Configuration latency: config accepted at edge N gives `st_valid=1` with the first matrix in the cycle after edge N.
- Throughput: one state per cycle with `st_ready` held high. Next matrix is visible the cycle after each handshake.
- `done`: asserted for exactly the cycle after the final handshake edge. `cfg_ready` is high in that same cycle, so back-to-back jobs are allowed.
- `st_ready` low stalls indefinitely with outputs frozen.

## Test plan
- RFC 8439 §2.3.2 vector, `CTR_WORDS=1`: key bytes 00..1f (words 03020100…1f1e1d1c), nonce 09000000/4a000000/00000000, ctr 1, `nblk=1` → row 3 = 00000001 09000000 4a000000 00000000, row 0 = expand-32 constants, `st_last=1`, `done` one cycle after the handshake.
- Streaming, `nblk=4`, `st_ready` toggling 1,0,1,1,0,1 → counters 1,2,3,4 each emitted exactly once, matrix frozen while stalled, `st_last` only on counter 4.
- Overflow: ctr FFFFFFFE, `nblk=3` → FFFFFFFE and FFFFFFFF emitted, then ERR with `ctr_ovf=1`, `st_valid=0`, no `done`. `abort` → IDLE; next config clears `ctr_ovf`.
- `CTR_WORDS=2`, ctr 00000000_FFFFFFFF, `nblk=2` → row 3 words [0],[1] go FFFFFFFF,00000000 then 00000000,00000001; nonce occupies [2],[3].
- `KEY128_EN=1`, `key_len=1` → row 0 = expand-16 constants, row 2 equals row 1. `nblk=0` → `done` pulse with no `st_valid`.
- `clrMatrix` asserted mid-stream at block 2 of 5 → matrix zero, `st_valid=0`, `cfg_ready=1` next cycle, no `done`.
